// File: rtl/pixel_ram_writer.sv
// pixel_ram_writer
// Write-side loader for the VGA frame buffer. Takes a raster-ordered pixel
// stream over a valid/ready handshake and turns every accepted pixel of a
// frame into one registered write (row, column, data, strobe), one cycle
// after acceptance. Frames start with a beat qualified by IN_SOF.
//
// Ports:
//   CLK        system clock, rising edge
//   RST        synchronous reset, active-high
//   IN_VALID   stream pixel valid
//   IN_READY   writer accepts a pixel this cycle (follows WR_ALLOW, low in reset)
//   IN_SOF     current beat is the first pixel of a frame
//   IN_DATA    pixel value
//   WR_ALLOW   write window from the display controller; low stalls the stream
//   WR_EN      frame buffer write strobe
//   WR_ROW     write row address
//   WR_COL     write column address
//   WR_DATA    write data
//   BUSY       a frame is in progress
//   FRAME_DONE one-cycle pulse together with the write of the last pixel
//   SYNC_ERR   one-cycle pulse together with the write of a mid-frame SOF
//   FRAME_CNT  completed-frame counter, wraps 255 -> 0
module pixel_ram_writer #(
  parameter int HEIGHT = 683,
  parameter int WIDTH  = 768,
  parameter int PIX_W  = 3,
  // A 1-row or 1-column buffer still needs a one-bit address port.
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             IN_SOF,
  input  logic [PIX_W-1:0] IN_DATA,
  input  logic             WR_ALLOW,
  output logic             WR_EN,
  output logic [ROW_W-1:0] WR_ROW,
  output logic [COL_W-1:0] WR_COL,
  output logic [PIX_W-1:0] WR_DATA,
  output logic             BUSY,
  output logic             FRAME_DONE,
  output logic             SYNC_ERR,
  output logic [7:0]       FRAME_CNT
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_ZERO = {ROW_W{1'b0}};
  localparam logic [COL_W-1:0] COL_ZERO = {COL_W{1'b0}};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  state_t             state_r, state_s;
  logic [ROW_W-1:0]   row_r, row_s;
  logic [COL_W-1:0]   col_r, col_s;
  logic               wr_en_r, wr_en_s;
  logic [ROW_W-1:0]   wr_row_r, wr_row_s;
  logic [COL_W-1:0]   wr_col_r, wr_col_s;
  logic [PIX_W-1:0]   wr_data_r, wr_data_s;
  logic               busy_r, busy_s;
  logic               frame_done_r, frame_done_s;
  logic               sync_err_r, sync_err_s;
  logic [7:0]         frame_cnt_r, frame_cnt_s;
  logic               accept_s;

  // Column that follows col in raster order.
  function automatic logic [COL_W-1:0] col_after(input logic [COL_W-1:0] col);
    if (col == LAST_COL) begin
      col_after = COL_ZERO;
    end else begin
      col_after = col + 1'b1;
    end
  endfunction

  // Row that follows (row, col) in raster order.
  function automatic logic [ROW_W-1:0] row_after(input logic [ROW_W-1:0] row,
                                                 input logic [COL_W-1:0] col);
    if (col == LAST_COL) begin
      row_after = row + 1'b1;
    end else begin
      row_after = row;
    end
  endfunction

  // True when (row, col) is the final pixel of the frame.
  function automatic logic is_last(input logic [ROW_W-1:0] row,
                                   input logic [COL_W-1:0] col);
    is_last = (row == LAST_ROW) && (col == LAST_COL);
  endfunction

  // Ready follows the write window, but never while reset is held.
  always_comb begin
    IN_READY = WR_ALLOW & ~RST;
  end

  // Next-state, raster counters and write-port values for this cycle's beat.
  always_comb begin
    state_s      = state_r;
    row_s        = row_r;
    col_s        = col_r;
    wr_en_s      = 1'b0;
    wr_row_s     = wr_row_r;
    wr_col_s     = wr_col_r;
    wr_data_s    = wr_data_r;
    frame_done_s = 1'b0;
    sync_err_s   = 1'b0;
    frame_cnt_s  = frame_cnt_r;
    accept_s     = IN_VALID & IN_READY;

    if (accept_s) begin
      if (IN_SOF) begin
        // A start-of-frame always restarts at (0,0); arriving in WRITE it
        // abandons the current frame and is flagged as a resync.
        wr_en_s    = 1'b1;
        wr_row_s   = ROW_ZERO;
        wr_col_s   = COL_ZERO;
        wr_data_s  = IN_DATA;
        sync_err_s = (state_r == ST_WRITE);
        if (is_last(ROW_ZERO, COL_ZERO)) begin
          // Single-pixel buffer: the SOF beat is also the last pixel.
          frame_done_s = 1'b1;
          frame_cnt_s  = frame_cnt_r + 8'd1;
          state_s      = ST_IDLE;
          row_s        = ROW_ZERO;
          col_s        = COL_ZERO;
        end else begin
          state_s = ST_WRITE;
          row_s   = row_after(ROW_ZERO, COL_ZERO);
          col_s   = col_after(COL_ZERO);
        end
      end else begin
        case (state_r)
          ST_WRITE: begin
            wr_en_s   = 1'b1;
            wr_row_s  = row_r;
            wr_col_s  = col_r;
            wr_data_s = IN_DATA;
            if (is_last(row_r, col_r)) begin
              frame_done_s = 1'b1;
              frame_cnt_s  = frame_cnt_r + 8'd1;
              state_s      = ST_IDLE;
              row_s        = ROW_ZERO;
              col_s        = COL_ZERO;
            end else begin
              row_s = row_after(row_r, col_r);
              col_s = col_after(col_r);
            end
          end
          ST_IDLE: begin
            // Pixels before the first SOF are dropped without a write.
            state_s = ST_IDLE;
          end
          default: begin
            state_s = ST_IDLE;
            row_s   = ROW_ZERO;
            col_s   = COL_ZERO;
          end
        endcase
      end
    end else begin
      // No beat: counters and address/data outputs hold, strobes stay low.
      state_s = state_r;
    end

    busy_s = (state_s == ST_WRITE);
  end

  // State, counters and registered write-port outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= ST_IDLE;
      row_r        <= ROW_ZERO;
      col_r        <= COL_ZERO;
      wr_en_r      <= 1'b0;
      wr_row_r     <= ROW_ZERO;
      wr_col_r     <= COL_ZERO;
      wr_data_r    <= {PIX_W{1'b0}};
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      sync_err_r   <= 1'b0;
      frame_cnt_r  <= 8'd0;
    end else begin
      state_r      <= state_s;
      row_r        <= row_s;
      col_r        <= col_s;
      wr_en_r      <= wr_en_s;
      wr_row_r     <= wr_row_s;
      wr_col_r     <= wr_col_s;
      wr_data_r    <= wr_data_s;
      busy_r       <= busy_s;
      frame_done_r <= frame_done_s;
      sync_err_r   <= sync_err_s;
      frame_cnt_r  <= frame_cnt_s;
    end
  end

  // Output port mapping.
  always_comb begin
    WR_EN      = wr_en_r;
    WR_ROW     = wr_row_r;
    WR_COL     = wr_col_r;
    WR_DATA    = wr_data_r;
    BUSY       = busy_r;
    FRAME_DONE = frame_done_r;
    SYNC_ERR   = sync_err_r;
    FRAME_CNT  = frame_cnt_r;
  end

endmodule

// File: tb/tb_pixel_ram_writer.sv
// Bench for pixel_ram_writer: a 4x5 instance (a) and a 1x1 instance (b),
// driven by directed and random beats and compared against a pixel-index
// reference model of the frame stream.
module tb_pixel_ram_writer;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests  = 0;
  int failed = 0;

  // Instance a: 4 rows x 5 columns.
  logic       rst_a = 1'b1, valid_a = 1'b0, sof_a = 1'b0, allow_a = 1'b0;
  logic [2:0] data_a = 3'd0;
  logic       ready_a, wr_en_a, busy_a, done_a, serr_a;
  logic [1:0] wr_row_a;
  logic [2:0] wr_col_a, wr_data_a;
  logic [7:0] cnt_a;

  // Instance b: single pixel buffer.
  logic       rst_b = 1'b1, valid_b = 1'b0, sof_b = 1'b0, allow_b = 1'b0;
  logic [2:0] data_b = 3'd0;
  logic       ready_b, wr_en_b, busy_b, done_b, serr_b;
  logic [0:0] wr_row_b, wr_col_b;
  logic [2:0] wr_data_b;
  logic [7:0] cnt_b;

  pixel_ram_writer #(.HEIGHT(4), .WIDTH(5), .PIX_W(3)) dut_a (
    .CLK(CLK), .RST(rst_a), .IN_VALID(valid_a), .IN_READY(ready_a),
    .IN_SOF(sof_a), .IN_DATA(data_a), .WR_ALLOW(allow_a), .WR_EN(wr_en_a),
    .WR_ROW(wr_row_a), .WR_COL(wr_col_a), .WR_DATA(wr_data_a), .BUSY(busy_a),
    .FRAME_DONE(done_a), .SYNC_ERR(serr_a), .FRAME_CNT(cnt_a)
  );

  pixel_ram_writer #(.HEIGHT(1), .WIDTH(1), .PIX_W(3)) dut_b (
    .CLK(CLK), .RST(rst_b), .IN_VALID(valid_b), .IN_READY(ready_b),
    .IN_SOF(sof_b), .IN_DATA(data_b), .WR_ALLOW(allow_b), .WR_EN(wr_en_b),
    .WR_ROW(wr_row_b), .WR_COL(wr_col_b), .WR_DATA(wr_data_b), .BUSY(busy_b),
    .FRAME_DONE(done_b), .SYNC_ERR(serr_b), .FRAME_CNT(cnt_b)
  );

  // Reference model state per instance: in-frame flag, index of the next
  // pixel in raster order, completed frames, last written address/data.
  int m_h[2] = '{4, 1};
  int m_w[2] = '{5, 1};
  int m_busy[2], m_idx[2], m_cnt[2], m_row[2], m_col[2], m_data[2];
  int hits[20];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock cycle on instance sel with the given inputs, then check all outputs.
  task automatic step(input int sel, input bit r, input bit v, input bit s,
                      input logic [2:0] d, input bit al);
    string nm;
    bit acc, e_en, e_done, e_serr;
    logic [31:0] o_ready, o_en, o_row, o_col, o_data, o_busy, o_done, o_serr, o_cnt;
    nm = (sel == 0) ? "a" : "b";
    if (sel == 0) begin
      rst_a = r; valid_a = v; sof_a = s; data_a = d; allow_a = al;
      rst_b = 1'b0; valid_b = 1'b0;
    end else begin
      rst_b = r; valid_b = v; sof_b = s; data_b = d; allow_b = al;
      rst_a = 1'b0; valid_a = 1'b0;
    end
    #1;
    o_ready = (sel == 0) ? 32'(ready_a) : 32'(ready_b);
    chk($sformatf("%s_in_ready", nm), o_ready, 32'(al && !r));

    acc = v && al && !r;
    e_en = 1'b0; e_done = 1'b0; e_serr = 1'b0;
    if (r) begin
      m_busy[sel] = 0; m_idx[sel] = 0; m_cnt[sel] = 0;
      m_row[sel] = 0; m_col[sel] = 0; m_data[sel] = 0;
    end else if (acc && (s || m_busy[sel] != 0)) begin
      e_en = 1'b1;
      if (s) begin
        e_serr = (m_busy[sel] != 0);
        m_idx[sel] = 0;
      end
      m_row[sel]  = m_idx[sel] / m_w[sel];
      m_col[sel]  = m_idx[sel] % m_w[sel];
      m_data[sel] = int'(d);
      if (m_idx[sel] == m_h[sel] * m_w[sel] - 1) begin
        e_done = 1'b1;
        m_cnt[sel] = (m_cnt[sel] + 1) % 256;
        m_busy[sel] = 0;
        m_idx[sel] = 0;
      end else begin
        m_busy[sel] = 1;
        m_idx[sel]++;
      end
    end

    @(posedge CLK);
    @(negedge CLK);
    if (sel == 0) begin
      o_en = 32'(wr_en_a); o_row = 32'(wr_row_a); o_col = 32'(wr_col_a);
      o_data = 32'(wr_data_a); o_busy = 32'(busy_a); o_done = 32'(done_a);
      o_serr = 32'(serr_a); o_cnt = 32'(cnt_a);
      if (o_en == 32'd1 && o_row < 32'd4 && o_col < 32'd5)
        hits[o_row * 5 + o_col]++;
    end else begin
      o_en = 32'(wr_en_b); o_row = 32'(wr_row_b); o_col = 32'(wr_col_b);
      o_data = 32'(wr_data_b); o_busy = 32'(busy_b); o_done = 32'(done_b);
      o_serr = 32'(serr_b); o_cnt = 32'(cnt_b);
    end
    chk($sformatf("%s_wr_en", nm),      o_en,   32'(e_en));
    chk($sformatf("%s_wr_row", nm),     o_row,  32'(m_row[sel]));
    chk($sformatf("%s_wr_col", nm),     o_col,  32'(m_col[sel]));
    chk($sformatf("%s_wr_data", nm),    o_data, 32'(m_data[sel]));
    chk($sformatf("%s_frame_done", nm), o_done, 32'(e_done));
    chk($sformatf("%s_sync_err", nm),   o_serr, 32'(e_serr));
    chk($sformatf("%s_frame_cnt", nm),  o_cnt,  32'(m_cnt[sel]));
    chk($sformatf("%s_busy", nm),       o_busy, 32'(m_busy[sel]));
  endtask

  initial begin
    // Reset with traffic present on both instances, then idle.
    step(0, 1'b1, 1'b1, 1'b0, 3'd5, 1'b1);
    step(0, 1'b1, 1'b1, 1'b0, 3'd5, 1'b1);
    step(0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    step(1, 1'b1, 1'b1, 1'b1, 3'd5, 1'b1);
    step(1, 1'b1, 1'b1, 1'b1, 3'd5, 1'b1);
    step(1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);

    // Full 4x5 frame, beat k carries k%8.
    for (int k = 0; k < 20; k++) step(0, 1'b0, 1'b1, (k == 0), 3'(k % 8), 1'b1);
    step(0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    chk("a_cnt_after_frame", 32'(cnt_a), 32'd1);
    chk("a_busy_after_frame", 32'(busy_a), 32'd0);

    // Beats before SOF are dropped; then a frame stalled 4 cycles at pixel 7.
    for (int k = 0; k < 3; k++) step(0, 1'b0, 1'b1, 1'b0, 3'($urandom_range(0, 7)), 1'b1);
    for (int k = 0; k < 20; k++) hits[k] = 0;
    for (int k = 0; k < 20; k++) begin
      if (k == 7) begin
        for (int j = 0; j < 4; j++) step(0, 1'b0, 1'b1, 1'b0, 3'd7, 1'b0);
      end
      step(0, 1'b0, 1'b1, (k == 0), 3'($urandom_range(0, 7)), 1'b1);
      if (k == 7) begin
        chk("a_pix7_row", 32'(wr_row_a), 32'd1);
        chk("a_pix7_col", 32'(wr_col_a), 32'd2);
      end
    end
    for (int k = 0; k < 20; k++) chk($sformatf("a_hits_%0d", k), 32'(hits[k]), 32'd1);
    chk("a_cnt_after_stall", 32'(cnt_a), 32'd2);

    // Mid-frame resync at beat 9, then a complete 20-beat frame.
    for (int k = 0; k < 9; k++) step(0, 1'b0, 1'b1, (k == 0), 3'($urandom_range(0, 7)), 1'b1);
    for (int k = 0; k < 20; k++) begin
      step(0, 1'b0, 1'b1, (k == 0), 3'($urandom_range(0, 7)), 1'b1);
      if (k == 0) chk("a_resync_err", 32'(serr_a), 32'd1);
      if (k == 1) chk("a_resync_next_col", 32'(wr_col_a), 32'd1);
      if (k == 18) chk("a_cnt_held", 32'(cnt_a), 32'd2);
    end
    chk("a_cnt_after_resync", 32'(cnt_a), 32'd3);

    // Reset mid-frame after 10 pixels, then a fresh SOF.
    for (int k = 0; k < 10; k++) step(0, 1'b0, 1'b1, (k == 0), 3'($urandom_range(0, 7)), 1'b1);
    step(0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
    step(0, 1'b0, 1'b1, 1'b1, 3'd6, 1'b1);
    chk("a_sof_after_rst_row", 32'(wr_row_a), 32'd0);
    chk("a_sof_after_rst_col", 32'(wr_col_a), 32'd0);

    // Random traffic: stalls, gaps, occasional SOF and reset.
    for (int k = 0; k < 400; k++) begin
      step(0, ($urandom_range(0, 96) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 22) == 0), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 4) != 0));
    end

    // 1x1 frames: every SOF beat completes a frame; counter wraps.
    step(1, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1);
    for (int k = 0; k < 256; k++) begin
      step(1, 1'b0, 1'b1, 1'b1, 3'($urandom_range(0, 7)), 1'b1);
      if (k == 254) chk("b_cnt_255", 32'(cnt_b), 32'd255);
    end
    chk("b_cnt_wrap", 32'(cnt_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pixel_ram_writer.md
Name: pixel_ram_writer

Overview:
- Write-side loader for the VGA frame buffer.
- Accepts a raster-ordered pixel stream over a valid/ready handshake and produces one registered write per accepted pixel (row, column, data, write enable) into the frame buffer's write port.
- Frames are delimited by a start-of-frame marker on the stream.
- Signals frame completion, resynchronisation errors and a running frame count to the display controller.

Parameters:
- HEIGHT, 683, number of pixel rows in the frame buffer
- WIDTH, 768, number of pixel columns in the frame buffer
- PIX_W, 3, bits per pixel

Ports:
- CLK  input  1  system clock; all state updates on rising edge
- RST  input  1  synchronous reset, active-high
- IN_VALID  input  1  stream pixel valid
- IN_READY  output  1  writer can accept a pixel this cycle
- IN_SOF  input  1  qualifies the current beat as the first pixel of a frame
- IN_DATA  input  PIX_W  pixel value
- WR_ALLOW  input  1  write window from the display controller; low stalls the stream
- WR_EN  output  1  frame buffer write strobe
- WR_ROW  output  $clog2(HEIGHT)  write row address
- WR_COL  output  $clog2(WIDTH)  write column address
- WR_DATA  output  PIX_W  write data
- BUSY  output  1  high while a frame is in progress (state WRITE)
- FRAME_DONE  output  1  one-cycle pulse with the write of the last pixel
- SYNC_ERR  output  1  one-cycle pulse when IN_SOF arrives mid-frame
- FRAME_CNT  output  8  completed-frame counter

Behaviour:
- Clocking and reset:
  - Single clock CLK. Reset is synchronous and active-high on RST.
  - During reset: state=IDLE; row/col counters=0; WR_EN=0; WR_ROW=0; WR_COL=0; WR_DATA=0; FRAME_DONE=0; SYNC_ERR=0; FRAME_CNT=0; BUSY=0.
  - Reset mid-frame abandons the frame with no FRAME_DONE. Already-written pixels stay in RAM.
- Handshake:
  - IN_READY = WR_ALLOW, combinational, in both states. While RST is high, IN_READY=0.
  - A beat is accepted when IN_VALID && IN_READY.
  - IN_DATA and IN_SOF are sampled only on accepted beats.
  - Dropping WR_ALLOW stalls the stream without loss; counters hold.
- Write pipeline:
  - Latency is 1 cycle: an accepted beat in cycle N gives WR_EN=1 in cycle N+1, with that beat's row, column and data.
  - WR_EN=0 in any cycle following a non-accepted cycle or a dropped beat.
  - WR_ROW, WR_COL and WR_DATA hold their last values when WR_EN=0.
- State IDLE:
  - Accepted beat with IN_SOF=0: dropped, no write.
  - Accepted beat with IN_SOF=1: write at (0,0); col<=1, row<=0; go to WRITE.
  - If WIDTH=1 and HEIGHT=1, the SOF beat also completes the frame.
- State WRITE, accepted beat with IN_SOF=0:
  - Write at (row,col).
  - Column advance: if col==WIDTH-1 then col<=0, row<=row+1; else col<=col+1.
  - If (row,col)==(HEIGHT-1,WIDTH-1):
    - FRAME_DONE=1 in the same cycle as that write's WR_EN.
    - FRAME_CNT increments in that cycle, wrapping 255->0.
    - Go to IDLE; counters return to 0.
- State WRITE, accepted beat with IN_SOF=1 (resync):
  - Write at (0,0); col<=1, row<=0; stay in WRITE.
  - SYNC_ERR=1 in the cycle of that write.
  - No FRAME_DONE, no FRAME_CNT change.
- Counters never exceed HEIGHT-1 / WIDTH-1. Address outputs are always in range.
- BUSY=1 from the cycle after the accepted SOF beat until the cycle after the last-pixel beat.

Test Plan:
- Reset and idle (defaults): assert RST 2 cycles with IN_VALID=1 and WR_ALLOW=1 -> all outputs 0, IN_READY=0; after release, IN_READY=1, BUSY=0.
- Full frame (HEIGHT=4, WIDTH=5): SOF plus 20 beats with data=index%8 -> 20 WR_EN pulses; addresses (0,0)..(0,4),(1,0)..(3,4); beat k has WR_DATA=k%8; FRAME_DONE only with (3,4); FRAME_CNT=1; BUSY=0 after.
- Pre-SOF drop and stall (HEIGHT=4, WIDTH=5): 3 beats without SOF, then a frame with WR_ALLOW low 4 cycles at pixel 7 -> no writes for the 3 beats; IN_READY=0 during the stall; pixel 7 writes at (1,2) after the stall; all 20 addresses written exactly once.
- Mid-frame resync (HEIGHT=4, WIDTH=5): SOF at beat 9 -> SYNC_ERR pulse with the write at (0,0); next write at (0,1); FRAME_CNT unchanged until 20 more beats, then 1.
- Reset mid-frame plus counter wrap: RST after 10 pixels -> no FRAME_DONE, next SOF writes (0,0). Then 256 back-to-back 1x1 frames (HEIGHT=1, WIDTH=1) -> FRAME_DONE every beat; FRAME_CNT reads 255 then 0.
- Default size: one 683x768 frame -> 524544 writes; last write at (682,767) with FRAME_DONE.
